// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared state encoding and protocol constants for the USB receive control unit
package usb_rx_pkg;
  typedef enum logic [3:0] {
    IDLE, SYNC_WAIT, SYNC_CHK, PID_WAIT, PID_CHK, DATA_WAIT, DATA_STORE,
    EOP_WAIT, ERR, ERR_EOP, ERR_IDLE
  } rcu_state_t;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;
  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
endpackage

// File: rtl/usb_rx_rcu.sv
// usb_rx_rcu: USB receive control unit validating SYNC/PID, strobing FIFO writes, flagging done/error
// Inputs: d_edge/eop from line detectors, shift_enable/byte_received/bit_cnt from the timer,
// rcv_data from the shift register, buf_full from the RX FIFO.
// Outputs (all registered): rcving to the timer, w_enable to the FIFO, pid/pid_valid,
// byte_count, rx_done pulse and sticky r_error.
module usb_rx_rcu
  import usb_rx_pkg::*;
#(
  parameter int          MAX_BYTES = 64,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [3:0] bit_cnt,
  input  logic [7:0] rcv_data,
  input  logic       buf_full,
  output logic       rcving,
  output logic       w_enable,
  output logic [3:0] pid,
  output logic       pid_valid,
  output logic [6:0] byte_count,
  output logic       rx_done,
  output logic       r_error
);
  if (MAX_BYTES > 127) begin : g_max_bytes_chk
    $error("usb_rx_rcu: MAX_BYTES must be <= 127");
  end
  localparam logic [6:0] MAXB = 7'(MAX_BYTES);
  rcu_state_t state, nxt;
  logic eop_s, wr, pv, start;
  assign eop_s = eop & shift_enable;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:       nxt = d_edge ? SYNC_WAIT : IDLE;
      SYNC_WAIT:  nxt = byte_received ? SYNC_CHK : eop_s ? ERR_EOP : SYNC_WAIT;
      SYNC_CHK:   nxt = rcv_data == SYNC_BYTE ? PID_WAIT : ERR;
      PID_WAIT:   nxt = byte_received ? PID_CHK : eop_s ? ERR_EOP : PID_WAIT;
      PID_CHK:    nxt = rcv_data[3:0] == ~rcv_data[7:4] ? DATA_WAIT : ERR;
      DATA_WAIT:  nxt = byte_received ? DATA_STORE : !eop_s ? DATA_WAIT : bit_cnt == 4'd0 ? EOP_WAIT : ERR_EOP;
      DATA_STORE: nxt = buf_full || byte_count == MAXB ? ERR : DATA_WAIT;
      EOP_WAIT:   nxt = d_edge ? IDLE : EOP_WAIT;
      ERR:        nxt = eop_s ? ERR_EOP : ERR;
      ERR_EOP:    nxt = d_edge ? ERR_IDLE : ERR_EOP;
      ERR_IDLE:   nxt = d_edge ? SYNC_WAIT : ERR_IDLE;
      default:    nxt = IDLE;
    endcase
  end
  assign wr    = state == DATA_STORE && nxt == DATA_WAIT;
  assign pv    = state == PID_CHK && nxt == DATA_WAIT;
  assign start = nxt == SYNC_WAIT && state != SYNC_WAIT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rcving     <= 1'b0;
      w_enable   <= 1'b0;
      pid        <= '0;
      pid_valid  <= 1'b0;
      byte_count <= '0;
      rx_done    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      state      <= nxt;
      rcving     <= !(nxt inside {IDLE, ERR_IDLE});
      r_error    <= nxt inside {ERR, ERR_EOP, ERR_IDLE};
      w_enable   <= wr;
      pid_valid  <= pv;
      rx_done    <= state == EOP_WAIT && nxt == IDLE;
      if (pv) pid <= rcv_data[3:0];
      if (start) byte_count <= '0;
      else if (wr) byte_count <= byte_count + 7'd1;
    end
  end
endmodule

// File: doc/usb_rx_rcu.md
Name: usb_rx_rcu

Overview:
Receive control unit for the USB receiver. It sequences the bit/byte timer by driving `rcving`. It consumes `shift_enable`, `byte_received` and the timer bit count, together with the shift-register byte and the EOP detector. From these it validates SYNC and PID, issues one-cycle write strobes into the RX FIFO, and reports packet completion or error. It sits between the edge/EOP detectors, the timer, the shift register and the RX FIFO.

Parameters:
- MAX_BYTES, 64: maximum data bytes accepted per packet; the next byte is an overflow error.
- SYNC_BYTE, 8'h80: required value of the first received byte.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- d_edge  in  1  one-cycle pulse on a D+/D- transition
- eop  in  1  SE0 currently detected on the line
- shift_enable  in  1  bit-sample strobe from the timer
- byte_received  in  1  one-cycle pulse when the timer completes 8 bits
- bit_cnt  in  4  timer bit count within the current byte (0..8)
- rcv_data  in  8  shift-register contents, valid in the cycle after byte_received
- buf_full  in  1  RX FIFO full
- rcving  out  1  enables the timer; high from packet start until EOP handled
- w_enable  out  1  one-cycle FIFO write strobe for rcv_data
- pid  out  4  last valid PID, registered
- pid_valid  out  1  one-cycle pulse when pid updates
- byte_count  out  7  data bytes written in the current packet
- rx_done  out  1  one-cycle pulse on error-free packet end
- r_error  out  1  sticky error flag

Behaviour:
- Reset: state IDLE; all outputs 0, including pid and byte_count. Reset wins over every other input in the same cycle, including mid-packet; no w_enable or pulse is issued in the reset cycle or the cycle after.
- Outputs are Moore, registered from state; the next-state decision uses current inputs.
- "EOP strobe" means eop & shift_enable in the same cycle.
- IDLE:
  - rcving=0.
  - d_edge -> SYNC_WAIT; byte_count cleared to 0.
- SYNC_WAIT:
  - rcving=1.
  - byte_received -> SYNC_CHK.
  - EOP strobe -> ERR_EOP.
- SYNC_CHK (1 cycle): rcv_data==SYNC_BYTE -> PID_WAIT, else ERR.
- PID_WAIT:
  - byte_received -> PID_CHK.
  - EOP strobe -> ERR_EOP.
- PID_CHK (1 cycle): if rcv_data[3:0] == ~rcv_data[7:4], latch pid=rcv_data[3:0], pulse pid_valid next cycle, go to DATA_WAIT; else ERR.
- DATA_WAIT:
  - byte_received -> DATA_STORE.
  - EOP strobe with bit_cnt==0 -> EOP_WAIT.
  - EOP strobe with bit_cnt!=0 (partial byte) -> ERR_EOP.
- DATA_STORE (1 cycle), checked in this order:
  - buf_full -> ERR, no write.
  - byte_count==MAX_BYTES -> ERR, no write.
  - otherwise w_enable=1, byte_count+1, -> DATA_WAIT.
  - Net latency: w_enable is high exactly 2 cycles after the byte_received pulse.
- EOP_WAIT:
  - rcving=1.
  - d_edge (line returns to J) -> IDLE; rx_done pulses for 1 cycle on entry to IDLE.
- ERR:
  - r_error=1, rcving=1, w_enable forced 0.
  - EOP strobe -> ERR_EOP.
- ERR_EOP:
  - r_error=1, rcving=1.
  - d_edge -> ERR_IDLE.
- ERR_IDLE:
  - r_error=1, rcving=0.
  - d_edge -> SYNC_WAIT; r_error cleared and byte_count cleared in the same transition.
- Simultaneous events:
  - byte_received and an EOP strobe in the same cycle: byte_received takes priority; EOP is re-evaluated in the next wait state.
  - d_edge in SYNC_WAIT through DATA_STORE is ignored.
- Width rules:
  - byte_count saturates by construction; it never exceeds MAX_BYTES.
  - MAX_BYTES must be ≤127; elaboration fails otherwise.
  - r_error and rx_done are never high together.

Decomposition:
- Package usb_rx_pkg holds:
  - rcu_state_t enum (IDLE, SYNC_WAIT, SYNC_CHK, PID_WAIT, PID_CHK, DATA_WAIT, DATA_STORE, EOP_WAIT, ERR, ERR_EOP, ERR_IDLE)
  - SYNC_BYTE default constant
  - PID code constants (OUT, IN, DATA0, DATA1, ACK, NAK)
- Single module; the PID check is a one-line compare and needs no sub-module.

Test Plan:
- Good packet: d_edge, SYNC 8'h80, PID 8'hC3 (DATA0), 2 data bytes 8'hA5/8'h5A, EOP strobe at bit_cnt=0, d_edge -> pid=4'h3, one pid_valid pulse, two w_enable pulses each 2 cycles after byte_received, byte_count=2, rx_done pulse, r_error=0, rcving low after the final d_edge.
- Bad SYNC: first byte 8'h81 -> ERR, r_error=1, no w_enable; after EOP strobe and d_edge, rcving=0 and r_error stays 1; next d_edge clears r_error and rcving=1.
- Bad PID 8'hC4 -> r_error=1, pid unchanged from its previous value, pid_valid never pulses.
- Partial-byte EOP: EOP strobe in DATA_WAIT with bit_cnt=5 -> ERR_EOP, r_error=1, no rx_done.
- Overflow: MAX_BYTES=4 with 5 data bytes -> exactly 4 w_enable pulses, byte_count=4, r_error=1. Separately, buf_full=1 at the first DATA_STORE -> r_error=1 and 0 writes.
- Reset mid-packet: rst asserted in DATA_WAIT after 3 bytes -> next cycle all outputs 0, state IDLE; the following d_edge starts a fresh packet with byte_count=0.
